hex_entry_controller: RTL and testbench
=======================================

Name: hex_entry_controller

Overview:
Manual register-write path, the counterpart to the seven-segment register viewer. The operator keys a 16-bit value in as four hex nibbles using sw[3:0] and a pushbutton, then picks the target register r1..r8 with sw_sel[2:0]. The block issues one write request/acknowledge transaction to the register file. It also exposes the partially entered value so the display path can echo it during entry.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a debounced key level changes (bench uses 4)
CNT_W, 18, width of the debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock; all logic on rising edge
resetn  input  1  synchronous active-low reset
sw_nib  input  4  hex nibble to enter
sw_sel  input  3  target register select (000=r1 .. 111=r8)
key_enter_n  input  1  raw pushbutton, active-low, asynchronous: append nibble
key_commit_n  input  1  raw pushbutton, active-low, asynchronous: write value
key_clr_n  input  1  raw pushbutton, active-low, asynchronous: discard entry
wr_req  output  1  write request to register file
wr_addr  output  3  register index, stable while wr_req=1
wr_data  output  16  write data, stable while wr_req=1
wr_ack  input  1  register file accepted the write
entry_val  output  16  value entered so far (for seven-seg echo)
nib_cnt  output  3  nibbles entered, 0..4
busy  output  1  high while state == REQ

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Reset values: state=IDLE; wr_req=0; wr_addr=0; wr_data=0; entry_val=0; nib_cnt=0; debounced key levels=1 (released); debounce counters=0. Reset mid-transaction drops wr_req on the next edge and aborts the write.
- Key conditioning, per key:
  - 2-flop synchroniser feeds the debouncer.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a 1-cycle pulse on a debounced 1->0 transition. Release generates no event.
  - Latency: raw input low and stable -> pulse after 2+DEBOUNCE_CYCLES cycles.
- FSM has three states: IDLE, ENTRY, REQ.
- IDLE:
  - enter: entry_val<={entry_val[11:0],sw_nib}, nib_cnt<=1, go to ENTRY.
  - commit: ignored.
  - clr: no-op.
- ENTRY:
  - enter with nib_cnt<4: shift as above, nib_cnt++.
  - enter with nib_cnt==4: ignored; value saturates, no shift.
  - commit: wr_addr<=sw_sel, wr_data<=entry_val, wr_req<=1, go to REQ.
  - clr: entry_val<=0, nib_cnt<=0, go to IDLE.
  - Simultaneous events priority: clr > commit > enter. Losing events are discarded.
- REQ:
  - Holds wr_req=1 and keeps wr_addr and wr_data stable.
  - On the cycle wr_ack=1 is sampled: wr_req<=0, entry_val<=0, nib_cnt<=0, go to IDLE.
  - wr_ack may already be high on the first REQ cycle; wr_req is then high for exactly one cycle.
  - All key events during REQ, including clr, are discarded.
  - wr_ack outside REQ is ignored.
- Shift order: nibbles shift into the LSB, so the first nibble entered ends up as the most significant of those entered. Fewer than 4 nibbles leaves the upper bits zero-extended.
- busy is combinational from state; all other outputs are registered.

Optional Feature:
HEX_ENTRY_AUTOCOMMIT_EN
- Defined: the enter event that makes nib_cnt reach 4 also launches the request in the same edge, using the updated value and sw_sel sampled that cycle (transitions ENTRY->REQ directly). key_commit_n remains functional for short entries.
- Undefined: REQ is entered only via commit, as described above.

Decomposition:
- Shared package/include hex_entry_pkg:
  - FSM state encodings (IDLE=2'd0, ENTRY=2'd1, REQ=2'd2)
  - NIB_MAX=4
  - default DEBOUNCE_CYCLES
- Sub-module key_debounce: synchroniser, counter, press pulse; parameterised by DEBOUNCE_CYCLES. Instantiated three times, once per key.

Test Plan:
- Enter nibbles A,B,C,D; sw_sel=3'b010; commit; wr_ack after 3 cycles -> wr_req held 3 cycles with wr_addr=2, wr_data=16'hABCD; then IDLE with entry_val=0.
- Bounce key_enter_n low/high every 2 cycles (DEBOUNCE_CYCLES=4), then hold low 10 cycles -> exactly one press pulse, nib_cnt=1.
- Enter 5 nibbles 1,2,3,4,5 -> entry_val=16'h1234, nib_cnt=4. With HEX_ENTRY_AUTOCOMMIT_EN: REQ after the 4th nibble, wr_data=16'h1234.
- Enter 7, assert commit and clr pulses in the same cycle -> no wr_req; IDLE, entry_val=0.
- In REQ with wr_ack held 0, press clr and enter -> wr_data unchanged and wr_req stays 1; assert wr_ack -> wr_req falls next edge.
- Assert resetn=0 mid-REQ -> next edge wr_req=0, all outputs 0; commit pressed in IDLE -> no request.

Source files
------------

// File: rtl/hex_entry_pkg.sv
// Shared definitions for the hex entry controller: FSM encoding, entry limits
// and default debounce sizing.
package hex_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        REQ   = 2'd2
    } state_e;

    localparam int NIB_MAX             = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int CNT_W_DEF           = 18;

    // New nibble enters at the LSB so the first key ends up most significant.
    function automatic logic [15:0] shift_nib(input logic [15:0] val, input logic [3:0] nib);
        return {val[11:0], nib};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each debounced release-to-press transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Counter only runs while the synchronised input disagrees with the level;
    // any agreement (a bounce) restarts it from zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/hex_entry_controller.sv
// Manual register-write path: four hex nibbles keyed in, then one req/ack
// write. Optional macro HEX_ENTRY_AUTOCOMMIT_EN launches the write on the 4th nibble.
//
// state | meaning
// IDLE  | no nibbles entered, entry_val = 0
// ENTRY | 1..4 nibbles entered, waiting for more, commit or clear
// REQ   | write request outstanding, waiting for wr_ack
module hex_entry_controller
    import hex_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  sw_nib,
    input  logic [2:0]  sw_sel,
    input  logic        key_enter_n,
    input  logic        key_commit_n,
    input  logic        key_clr_n,
    output logic        wr_req,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic [15:0] entry_val,
    output logic [2:0]  nib_cnt,
    output logic        busy
);

    localparam logic [2:0] NIB_FULL = 3'(NIB_MAX);

    logic enter_ev, commit_ev, clr_ev;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_enter (
        .clk     (clk),
        .resetn  (resetn),
        .key_n_i (key_enter_n),
        .press_o (enter_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_commit (
        .clk     (clk),
        .resetn  (resetn),
        .key_n_i (key_commit_n),
        .press_o (commit_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clr (
        .clk     (clk),
        .resetn  (resetn),
        .key_n_i (key_clr_n),
        .press_o (clr_ev)
    );

    state_e      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic [2:0]  nib_q, nib_d;
    logic        req_q, req_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] shifted;

    assign shifted = shift_nib(entry_q, sw_nib);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            entry_q <= '0;
            nib_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            nib_q   <= nib_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Event priority is clr > commit > enter; the losers are simply dropped.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        nib_d   = nib_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (!clr_ev && !commit_ev && enter_ev) begin
                    entry_d = shifted;
                    nib_d   = 3'd1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (clr_ev) begin
                    entry_d = '0;
                    nib_d   = '0;
                    state_d = IDLE;
                end else if (commit_ev) begin
                    addr_d  = sw_sel;
                    data_d  = entry_q;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else if (enter_ev && (nib_q < NIB_FULL)) begin
                    entry_d = shifted;
                    nib_d   = nib_q + 3'd1;
`ifdef HEX_ENTRY_AUTOCOMMIT_EN
                    if (nib_q == NIB_FULL - 3'd1) begin
                        addr_d  = sw_sel;
                        data_d  = shifted;
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
`endif
                end
            end
            REQ: begin
                if (wr_ack) begin
                    req_d   = 1'b0;
                    entry_d = '0;
                    nib_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign wr_req    = req_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign entry_val = entry_q;
    assign nib_cnt   = nib_q;
    assign busy      = (state_q == REQ);

endmodule

// File: tb/tb_hex_entry_controller.sv
// Bench for hex_entry_controller: directed scenarios plus random key/ack
// traffic, all checked every cycle against a queue-based behavioural model.
module tb_hex_entry_controller;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  sw_nib;
    logic [2:0]  sw_sel;
    logic        raw_k [3];
    logic        wr_req;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [15:0] entry_val;
    logic [2:0]  nib_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hex_entry_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sw_nib       (sw_nib),
        .sw_sel       (sw_sel),
        .key_enter_n  (raw_k[0]),
        .key_commit_n (raw_k[1]),
        .key_clr_n    (raw_k[2]),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ack       (wr_ack),
        .entry_val    (entry_val),
        .nib_cnt      (nib_cnt),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the entry is a list of keyed nibbles; a key press
    // is recognised when the last D synchronised samples all oppose the level.
    logic [3:0]  nibs [$];
    bit          m_req;
    logic [2:0]  m_addr;
    logic [15:0] m_data;
    bit          hist [3][D+2];
    bit          lvl  [3];
    bit          pend [3];
    bit          model_valid = 0;

    function automatic logic [15:0] qval();
        logic [15:0] v = '0;
        foreach (nibs[i]) v = (v << 4) | 16'(nibs[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            nibs.delete();
            m_req = 0; m_addr = '0; m_data = '0;
            for (int k = 0; k < 3; k++) begin
                lvl[k] = 1; pend[k] = 0;
                for (int i = 0; i < D+2; i++) hist[k][i] = 1;
            end
        end else begin
            if (m_req) begin
                if (wr_ack) begin m_req = 0; nibs.delete(); end
            end else if (pend[2]) begin
                nibs.delete();
            end else if (pend[1]) begin
                if (nibs.size() > 0) begin m_req = 1; m_addr = sw_sel; m_data = qval(); end
            end else if (pend[0]) begin
                if (nibs.size() < 4) begin
                    nibs.push_back(sw_nib);
`ifdef HEX_ENTRY_AUTOCOMMIT_EN
                    if (nibs.size() == 4) begin m_req = 1; m_addr = sw_sel; m_data = qval(); end
`endif
                end
            end
            for (int k = 0; k < 3; k++) begin
                bit all_diff;
                for (int i = D+1; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = raw_k[k];
                all_diff = 1;
                for (int i = 2; i < D+2; i++) if (hist[k][i] == lvl[k]) all_diff = 0;
                pend[k] = 0;
                if (all_diff) begin
                    lvl[k]  = ~lvl[k];
                    pend[k] = (lvl[k] == 0);
                end
            end
        end
        model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("wr_req",    32'(wr_req),    32'(m_req));
            chk("busy",      32'(busy),      32'(m_req));
            chk("wr_addr",   32'(wr_addr),   32'(m_addr));
            chk("wr_data",   32'(wr_data),   32'(m_data));
            chk("entry_val", 32'(entry_val), 32'(qval()));
            chk("nib_cnt",   32'(nib_cnt),   32'(nibs.size()));
        end
    end

    task automatic hold(input int k, input int cyc);
        raw_k[k] = 1'b0;
        repeat (cyc) @(negedge clk);
        raw_k[k] = 1'b1;
    endtask

    task automatic press(input int k, input logic [3:0] nib);
        sw_nib = nib;
        hold(k, D+6);
        repeat (D+6) @(negedge clk);
    endtask

    task automatic ack_pulse();
        wr_ack = 1'b1;
        @(negedge clk);
        chk("req_falls_after_ack", 32'(wr_req), 32'd0);
        wr_ack = 1'b0;
    endtask

    initial begin
        int n;
        resetn = 1'b0; sw_nib = '0; sw_sel = '0; wr_ack = 1'b0;
        for (int k = 0; k < 3; k++) raw_k[k] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_entry",  32'(entry_val), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // ABCD to r3, ack arrives on the third request cycle
        press(0, 4'hA); press(0, 4'hB); press(0, 4'hC);
        sw_sel = 3'b010;
        sw_nib = 4'hD;
        hold(0, D+6);
        repeat (D+6) @(negedge clk);
        raw_k[1] = 1'b0;
        n = 0;
        while (!wr_req && n < 50) begin @(negedge clk); n++; end
        chk("abcd_req_seen", 32'(wr_req), 32'd1);
        n = 1;
        repeat (2) begin @(negedge clk); if (wr_req) n++; end
        chk("abcd_dut_data",   32'(wr_data), 32'hABCD);
        chk("abcd_model_data", 32'(m_data),  32'hABCD);
        chk("abcd_addr",       32'(wr_addr), 32'd2);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        chk("abcd_req_cycles", 32'(n), 32'd3);
        chk("abcd_req_low",    32'(wr_req), 32'd0);
        chk("abcd_entry_zero", 32'(entry_val), 32'd0);
        raw_k[1] = 1'b1;
        repeat (D+6) @(negedge clk);

        // bouncing enter key produces one press only
        sw_nib = 4'h6;
        repeat (3) begin
            raw_k[0] = 1'b0; repeat (2) @(negedge clk);
            raw_k[0] = 1'b1; repeat (2) @(negedge clk);
        end
        chk("bounce_no_press", 32'(nib_cnt), 32'd0);
        hold(0, 10);
        repeat (D+6) @(negedge clk);
        chk("bounce_nib_cnt", 32'(nib_cnt), 32'd1);
        chk("bounce_entry",   32'(entry_val), 32'h0006);
        press(2, 4'h0);

        // five nibbles saturate at four
        sw_sel = 3'b101;
        for (int i = 1; i <= 5; i++) press(0, 4'(i));
        chk("sat_dut_entry",   32'(entry_val), 32'h1234);
        chk("sat_model_entry", 32'(qval()),    32'h1234);
        chk("sat_nib_cnt",     32'(nib_cnt),   32'd4);
`ifdef HEX_ENTRY_AUTOCOMMIT_EN
        chk("auto_req",  32'(wr_req),  32'd1);
        chk("auto_data", 32'(wr_data), 32'h1234);
        ack_pulse();
`else
        chk("sat_no_req", 32'(wr_req), 32'd0);
        press(2, 4'h0);
`endif

        // commit and clr together: clr wins
        press(0, 4'h7);
        raw_k[1] = 1'b0; raw_k[2] = 1'b0;
        repeat (D+6) @(negedge clk);
        raw_k[1] = 1'b1; raw_k[2] = 1'b1;
        repeat (D+6) @(negedge clk);
        chk("clr_win_req",   32'(wr_req),    32'd0);
        chk("clr_win_entry", 32'(entry_val), 32'd0);
        chk("clr_win_cnt",   32'(nib_cnt),   32'd0);

        // keys ignored while request outstanding
        sw_sel = 3'b111;
        press(0, 4'h9);
        press(1, 4'h0);
        chk("req_hold_req", 32'(wr_req), 32'd1);
        press(2, 4'h0);
        press(0, 4'h3);
        chk("req_hold_req2",  32'(wr_req),    32'd1);
        chk("req_hold_data",  32'(wr_data),   32'h0009);
        chk("req_hold_addr",  32'(wr_addr),   32'd7);
        chk("req_hold_entry", 32'(entry_val), 32'h0009);
        ack_pulse();

        // reset while requesting
        press(0, 4'h5);
        press(1, 4'h0);
        chk("rstreq_req", 32'(wr_req), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstreq_wr_req", 32'(wr_req),    32'd0);
        chk("rstreq_addr",   32'(wr_addr),   32'd0);
        chk("rstreq_data",   32'(wr_data),   32'd0);
        chk("rstreq_entry",  32'(entry_val), 32'd0);
        chk("rstreq_busy",   32'(busy),      32'd0);
        resetn = 1'b1;
        press(1, 4'h0);
        chk("idle_commit_ignored", 32'(wr_req), 32'd0);

        // random traffic
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, (k == 0) ? 5 : 11) == 0) raw_k[k] = ~raw_k[k];
            sw_nib = 4'($urandom);
            sw_sel = 3'($urandom);
            wr_ack = ($urandom_range(0, 3) == 0);
            resetn = ($urandom_range(0, 1499) != 0);
        end
        @(negedge clk);
        resetn = 1'b1; wr_ack = 1'b0;
        for (int k = 0; k < 3; k++) raw_k[k] = 1'b1;
        repeat (2 * D + 6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
